ext_interleaver: RTL and testbench
==================================

# ext_interleaver

Extrinsic-LLR interleaver buffer between two turbo-decoder SISO stages. It captures one block of K extrinsic values produced by a `Siso` instance on its 10-bit `data_o`, saturates each to the 7-bit LLR format, and stores it. It then replays the block in QPP-interleaved or QPP-deinterleaved order, ready to drive the next `Siso` instance's `ext_i` port. A single buffer alternates between write and read phases, with valid/ready handshakes on both sides.

## Interface
- `K`, 16: block length; ≥ 2.
- `IN_W`, 10: input width; signed two's complement.
- `OUT_W`, 7: output width; signed two's complement.
- `F1`, 1: QPP coefficient f1. Odd and coprime to K.
- `F2`, 4: QPP coefficient f2. Contains every prime factor of K.
- `AW`, $clog2(K): address width; derived, not overridden.

- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_n_i` in 1: reset, **asynchronous, active-low**.
- `mode_i` in 1: 0 = interleave, 1 = deinterleave. Sampled on the first accepted input beat of each block.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: block can accept an input beat.
- `in_data_i` in IN_W: extrinsic LLR from the SISO.
- `out_valid_o` out 1: `out_data_o` is valid.
- `out_ready_i` in 1: consumer accepts the output beat.
- `out_data_o` out OUT_W: saturated LLR, to the next SISO's `ext_i`.
- `out_last_o` out 1: current output beat is the K-th beat of the block.
- `sat_o` out 1: sticky flag; at least one input of the current block saturated.
- `done_o` out 1: one-cycle pulse after the last output beat is accepted.

## Operation
- **Permutation:** π(i) = (F1·i + F2·i²) mod K.
  - Generated recursively, with no multiplier: π(0)=0, g(0)=(F1+F2) mod K, π(i+1)=(π(i)+g(i)) mod K, g(i+1)=(g(i)+2F2) mod K.
  - Each mod is a single conditional subtract of K.
- **FSM states: IDLE, WRITE, READ.**
  - IDLE: `in_ready_o`=1. The first accepted beat latches `mode_i`, clears `sat_o`, writes entry 0, and moves to WRITE (or to READ if K is reached).
  - WRITE: `in_ready_o`=1. Each handshake writes one entry and increments the counter. The handshake that writes the K-th entry moves to READ.
  - READ: `in_ready_o`=0; `in_valid_i` is ignored. The output register loads whenever (!`out_valid_o` || `out_ready_i`) and beats remain. Accepting the K-th output beat moves to IDLE.
- **Addressing:**
  - mode 0: write at address i, read at π(k), so output k = input π(k).
  - mode 1: write at π(i), read at address k, so output π(i) = input i.
- **Saturation:** values > 2^(OUT_W−1)−1 clamp to 63; values < −2^(OUT_W−1) clamp to −64. Any clamp sets `sat_o`.
- **Memory:** K×OUT_W register array, not reset.

## Timing
- **Reset values:**
  - `in_ready_o`=1.
  - `out_valid_o`, `out_last_o`, `sat_o`, `done_o` = 0.
  - `out_data_o`=0.
  - FSM = IDLE; counters, π, and g return to their initial values.
  - Asserting reset mid-block aborts the block: no `done_o` pulse; the next block starts clean.
- **Input side:** a handshake occurs on `in_valid_i` && `in_ready_o`. Throughput is one beat per cycle.
- **Write-to-read latency:** if the K-th input handshake is in cycle t, `out_valid_o` first rises in cycle t+2.
- **Output stability:** while `out_valid_o`=1 && `out_ready_i`=0, `out_data_o` and `out_last_o` hold stable. With `out_ready_i` held at 1, the block delivers one beat per cycle.
- **Block completion:** if the last output handshake is in cycle u:
  - in cycle u+1: `done_o`=1, `out_valid_o`=0, `in_ready_o`=1.
  - a new block may start in cycle u+1.
- **`sat_o`:** holds its value from the start of a block until the first beat of the next block.

## Test plan
- Interleave: mode 0, inputs 0..15 back-to-back, `out_ready_i`=1. Required outputs: 0,5,2,7,4,9,6,11,8,13,10,15,12,1,14,3. `out_last_o` on the 16th beat, `done_o` one cycle later, first output at t+2.
- Deinterleave: mode 1, inputs 0..15. Required outputs: 0,13,2,15,4,1,6,3,8,5,10,7,12,9,14,11. Chaining this block after the interleave case returns 0..15.
- Saturation: inputs 10'h1FF, 10'h200, 63, −64, then 0 for the rest. Required outputs (mode 0, first beats): 7'h3F, 7'h40, 7'h3F, 7'h40 at the permuted positions. `sat_o`=1, cleared on the next block's first beat.
- Backpressure: random `out_ready_i` and random gaps on `in_valid_i`. `out_data_o` holds stable while stalled; the output sequence is identical to the first case; `in_valid_i` pulses during READ are not consumed.
- Reset mid-READ after 7 outputs. All outputs reach their reset values immediately, with no `done_o`. The next full block produces the correct sequence.
- Back-to-back blocks: mode 0, then mode 1, with the new block's first beat in the `done_o` cycle. Both sequences are correct.

Source files
------------

// File: rtl/ext_interleaver.sv
// Extrinsic-LLR interleaver buffer: captures K saturated LLRs, then replays them
// in QPP-interleaved (mode 0) or QPP-deinterleaved (mode 1) order.
module ext_interleaver #(
  parameter int unsigned K     = 16,
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 7,
  parameter int unsigned F1    = 1,
  parameter int unsigned F2    = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_last_o,
  output logic             sat_o,
  output logic             done_o
);

  localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned G0 = (F1 + F2) % K;
  localparam int unsigned G2 = (2 * F2) % K;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      pi_q, pi_d;
  logic [AW-1:0]      g_q, g_d;
  logic               mode_q, mode_d;
  logic               sat_q, sat_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;

  logic [OUT_W-1:0]   mem_q [K];

  logic               over_c, under_c, clamp_c;
  logic [OUT_W-1:0]   sat_val_c;
  logic               we_c;
  logic [AW-1:0]      waddr_c, raddr_c;
  logic               wmode_c, load_c, out_hs_c;

  // Single conditional subtract keeps a + b inside [0, K)
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (AW+1)'(K)) s = s - (AW+1)'(K);
    return s[AW-1:0];
  endfunction

  // Clamp the wide input LLR into the OUT_W-bit signed range
  always_comb begin
    over_c  = !in_data_i[IN_W-1] && (|in_data_i[IN_W-2:OUT_W-1]);
    under_c = in_data_i[IN_W-1] && !(&in_data_i[IN_W-2:OUT_W-1]);
    clamp_c = over_c || under_c;
    if (over_c)       sat_val_c = {1'b0, {(OUT_W-1){1'b1}}};
    else if (under_c) sat_val_c = {1'b1, {(OUT_W-1){1'b0}}};
    else              sat_val_c = in_data_i[OUT_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pi_d        = pi_q;
    g_d         = g_q;
    mode_d      = mode_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    we_c        = 1'b0;
    wmode_c     = (state_q == S_IDLE) ? mode_i : mode_q;
    waddr_c     = wmode_c ? pi_q : cnt_q[AW-1:0];
    raddr_c     = mode_q ? cnt_q[AW-1:0] : pi_q;
    out_hs_c    = out_valid_q && out_ready_i;
    load_c      = 1'b0;

    case (state_q)
      S_IDLE, S_WRITE: begin
        if (in_valid_i) begin
          we_c  = 1'b1;
          cnt_d = cnt_q + CW'(1);
          pi_d  = mod_add(pi_q, g_q);
          g_d   = mod_add(g_q, AW'(G2));
          if (state_q == S_IDLE) begin
            mode_d = mode_i;
            sat_d  = clamp_c;
          end else begin
            sat_d  = sat_q | clamp_c;
          end
          state_d = S_WRITE;
          // Last entry written: rewind the address generator for replay
          if (cnt_q == CW'(K - 1)) begin
            state_d = S_READ;
            cnt_d   = '0;
            pi_d    = '0;
            g_d     = AW'(G0);
          end
        end
      end
      S_READ: begin
        load_c = (cnt_q < CW'(K)) && (!out_valid_q || out_ready_i);
        if (load_c) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_q[raddr_c];
          out_last_d  = (cnt_q == CW'(K - 1));
          cnt_d       = cnt_q + CW'(1);
          pi_d        = mod_add(pi_q, g_q);
          g_d         = mod_add(g_q, AW'(G2));
        end else if (out_hs_c) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (out_hs_c && out_last_q) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          cnt_d       = '0;
          pi_d        = '0;
          g_d         = AW'(G0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d != S_READ);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pi_q        <= '0;
      g_q         <= AW'(G0);
      mode_q      <= 1'b0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pi_q        <= pi_d;
      g_q         <= g_d;
      mode_q      <= mode_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Block storage carries no reset; every entry is rewritten before it is read
  always_ff @(posedge clk_i) begin
    if (we_c) mem_q[waddr_c] <= sat_val_c;
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign sat_o       = sat_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_ext_interleaver.sv
// Self-checking bench for ext_interleaver: behavioural QPP/saturation model with
// a per-cycle output scoreboard, plus literal sequences for the directed cases.
module tb_ext_interleaver;
  localparam int K = 16;
  localparam int IN_W = 10;
  localparam int OUT_W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic out_last, sat, done;

  ext_interleaver #(.K(K), .IN_W(IN_W), .OUT_W(OUT_W), .F1(1), .F2(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .sat_o(sat), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    bit               last;
  } beat_t;

  beat_t            exp_q[$];
  logic [OUT_W-1:0] out_log[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  beats_acc = 0;
  bit  rand_rdy = 1'b0;
  bit  exp_sat = 1'b0;

  int il_ref[K] = '{0, 5, 2, 7, 4, 9, 6, 11, 8, 13, 10, 15, 12, 1, 14, 3};
  int de_ref[K] = '{0, 13, 2, 15, 4, 1, 6, 3, 8, 5, 10, 7, 12, 9, 14, 11};
  int ramp[K];

  function automatic int perm(input int i);
    return (1 * i + 4 * i * i) % K;
  endfunction

  function automatic logic [OUT_W-1:0] sat7(input int v);
    if (v > 63) return 7'h3F;
    if (v < -64) return 7'h40;
    return 7'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output consumer pacing
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle scoreboard; sampled mid-cycle so the next edge's handshake is known
  bit               done_exp = 1'b0;
  bit               prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  bit               prev_last;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      done_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done_pulse", int'(done), int'(done_exp));
      if (done_exp) begin
        chk("ready_after_done", int'(in_ready), 1);
        chk("valid_after_done", int'(out_valid), 0);
      end
      done_exp = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(prev_data));
        chk("stall_last", int'(out_last), int'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out_beat");
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(e.d));
          chk("out_last", int'(out_last), int'(e.last));
          if (e.last) done_exp = 1'b1;
        end
        out_log.push_back(out_data);
        beats_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic send_block(input bit m, input int vals[K], input bit gaps, input bit chk_clr);
    int src[K];
    int n;
    exp_sat = 1'b0;
    out_log.delete();
    beats_acc = 0;
    for (int i = 0; i < K; i++) begin
      if (m) src[perm(i)] = vals[i];
      else   src[i] = vals[perm(i)];
      if (vals[i] > 63 || vals[i] < -64) exp_sat = 1'b1;
    end
    for (int k = 0; k < K; k++) exp_q.push_back(beat_t'{sat7(src[k]), (k == K - 1)});
    for (int i = 0; i < K; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      n = 0;
      while (!in_ready && n < 600) begin
        in_valid = 1'b0;
        step();
        n++;
      end
      if (!in_ready) begin
        fail_now("in_ready_timeout");
        break;
      end
      in_valid = 1'b1;
      in_data  = IN_W'(vals[i]);
      mode     = m;
      step();
      if (i == 0 && chk_clr) chk("sat_cleared", int'(sat), 0);
    end
    in_valid = 1'b0;
  endtask

  // Returns in the done_o cycle; optionally pokes in_valid while in_ready_o is low
  task automatic wait_done(input bit junk);
    int n = 0;
    while (!done && n < 800) begin
      if (junk && !in_ready) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = IN_W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!done) fail_now("done_timeout");
    else chk("sat_flag", int'(sat), int'(exp_sat));
  endtask

  task automatic chk_log(input string nm, input int ref_a[K]);
    chk({nm, "_count"}, out_log.size(), K);
    if (out_log.size() == K)
      for (int k = 0; k < K; k++) chk(nm, int'(out_log[k]), ref_a[k]);
  endtask

  initial begin
    int vals[K];
    int n;
    for (int i = 0; i < K; i++) ramp[i] = i;

    // Reset values
    repeat (3) step();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    step();

    // Interleave ramp, with write-to-read latency
    send_block(1'b0, ramp, 1'b0, 1'b0);
    chk("latency_t1", int'(out_valid), 0);
    step();
    chk("latency_t2", int'(out_valid), 1);
    wait_done(1'b0);
    chk_log("interleave", il_ref);
    step();

    // Deinterleave ramp, then deinterleave the interleaved sequence
    send_block(1'b1, ramp, 1'b0, 1'b0);
    wait_done(1'b0);
    chk_log("deinterleave", de_ref);
    step();
    send_block(1'b1, il_ref, 1'b0, 1'b0);
    wait_done(1'b0);
    chk_log("chain_roundtrip", ramp);
    step();

    // Saturation
    for (int i = 0; i < K; i++) vals[i] = 0;
    vals[0] = 511;
    vals[1] = -512;
    vals[2] = 63;
    vals[3] = -64;
    send_block(1'b0, vals, 1'b0, 1'b0);
    wait_done(1'b0);
    chk("sat_set", int'(sat), 1);
    if (out_log.size() == K) begin
      chk("sat_pos0", int'(out_log[0]), 'h3F);
      chk("sat_pos13", int'(out_log[13]), 'h40);
      chk("sat_pos2", int'(out_log[2]), 'h3F);
      chk("sat_pos15", int'(out_log[15]), 'h40);
      chk("sat_pos1", int'(out_log[1]), 0);
    end else begin
      fail_now("sat_log_size");
    end
    step();

    // Backpressure, input gaps, ignored in_valid during replay
    rand_rdy = 1'b1;
    send_block(1'b0, ramp, 1'b1, 1'b1);
    wait_done(1'b1);
    chk_log("backpressure", il_ref);
    rand_rdy = 1'b0;
    step();

    // Reset in the middle of replay
    for (int i = 0; i < K; i++) vals[i] = $urandom_range(0, 1023) - 512;
    send_block(1'b0, vals, 1'b0, 1'b0);
    n = 0;
    while (beats_acc < 7 && n < 200) begin
      step();
      n++;
    end
    if (beats_acc < 7) fail_now("mid_read_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_last", int'(out_last), 0);
    chk("abort_out_data", int'(out_data), 0);
    chk("abort_sat", int'(sat), 0);
    chk("abort_done", int'(done), 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    send_block(1'b0, ramp, 1'b0, 1'b0);
    wait_done(1'b0);
    chk_log("after_abort", il_ref);
    step();

    // Back-to-back: next block's first beat lands in the done_o cycle
    send_block(1'b0, ramp, 1'b0, 1'b0);
    wait_done(1'b0);
    chk_log("b2b_first", il_ref);
    send_block(1'b1, ramp, 1'b0, 1'b0);
    wait_done(1'b0);
    chk_log("b2b_second", de_ref);

    // Random blocks: random mode, data, pacing
    rand_rdy = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < K; i++)
        vals[i] = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1023) - 512)
                                              : ($urandom_range(0, 127) - 64);
      send_block(1'($urandom_range(0, 1)), vals, 1'b1, 1'b0);
      wait_done(1'b1);
      chk("rand_beats", beats_acc, K);
      if ($urandom_range(0, 1) == 1) step();
    end
    rand_rdy = 1'b0;
    repeat (4) step();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
